// File: rtl/player_hand.sv
// Per-seat blackjack hand: fetches cards from the deck on dealing strobes, keeps the running total.
// Optional build macro PLAYER_SOFT_ACE_EN: aces count 11 and are demoted to 1 when the hand would bust.
module player_hand #(
  parameter int STAND_THRESHOLD = 17,
  parameter int MAX_CARDS       = 5
) (
  input  logic       clock,
  input  logic       new_Game,
  input  logic       cardReady,
  input  logic       card_ack,
  input  logic [3:0] card_rank,
  output logic       card_req,
  output logic [4:0] totalValue,
  output logic       finish,
  output logic       bust,
  output logic [2:0] card_count,
  output logic       card_err
);

  localparam logic [4:0] THRESH = 5'(STAND_THRESHOLD);
  localparam logic [2:0] MAXC   = 3'(MAX_CARDS);

  typedef enum logic [2:0] {IDLE, REQ, ADD, CHECK, DONE} state_e;

  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic [3:0] rank_q, rank_d;
  logic [4:0] total_q, total_d;
  logic [2:0] count_q, count_d;
  logic       finish_q, finish_d;
  logic       bust_q, bust_d;
  logic       err_q, err_d;
  logic [4:0] card_val;
  logic [5:0] sum;
`ifdef PLAYER_SOFT_ACE_EN
  logic [2:0] soft_q, soft_d, soft_tmp;
`endif

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rank_d    = rank_q;
    total_d   = total_q;
    count_d   = count_q;
    finish_d  = finish_q;
    bust_d    = bust_q;
    err_d     = 1'b0;
    card_val  = 5'd0;
    sum       = 6'd0;
`ifdef PLAYER_SOFT_ACE_EN
    soft_d    = soft_q;
    soft_tmp  = soft_q;
`endif

    // A deal arriving while a card is in flight is owed, not lost.
    if (cardReady && (state_q == REQ || state_q == ADD || state_q == CHECK))
      pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (cardReady || pending_q) begin
          state_d   = REQ;
          pending_d = 1'b0;
        end
      end
      REQ: begin
        if (card_ack) begin
          if (card_rank inside {[4'd1:4'd13]}) begin
            rank_d  = card_rank;
            state_d = ADD;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ADD: begin
        if (rank_q == 4'd1) begin
`ifdef PLAYER_SOFT_ACE_EN
          card_val = 5'd11;
          soft_tmp = soft_q + 3'd1;
`else
          card_val = 5'd1;
`endif
        end else if (rank_q >= 4'd10) begin
          card_val = 5'd10;
        end else begin
          card_val = {1'b0, rank_q};
        end
        sum = {1'b0, total_q} + {1'b0, card_val};
`ifdef PLAYER_SOFT_ACE_EN
        if (sum > 6'd21 && soft_tmp != 3'd0) begin
          sum      = sum - 6'd10;
          soft_tmp = soft_tmp - 3'd1;
        end
        soft_d = soft_tmp;
`endif
        total_d = (sum > 6'd31) ? 5'd31 : sum[4:0];
        count_d = count_q + 3'd1;
        state_d = CHECK;
      end
      CHECK: begin
        if (total_q > 5'd21) begin
          bust_d   = 1'b1;
          finish_d = 1'b1;
          state_d  = DONE;
        end else if (total_q >= THRESH || count_q == MAXC) begin
          finish_d = 1'b1;
          state_d  = DONE;
        end else if (pending_q || cardReady) begin
          state_d   = REQ;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; new_Game is a synchronous clear that beats everything.
  always_ff @(posedge clock) begin
    if (new_Game) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      rank_q    <= 4'd0;
      total_q   <= 5'd0;
      count_q   <= 3'd0;
      finish_q  <= 1'b0;
      bust_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PLAYER_SOFT_ACE_EN
      soft_q    <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rank_q    <= rank_d;
      total_q   <= total_d;
      count_q   <= count_d;
      finish_q  <= finish_d;
      bust_q    <= bust_d;
      err_q     <= err_d;
`ifdef PLAYER_SOFT_ACE_EN
      soft_q    <= soft_d;
`endif
    end
  end

  assign card_req   = (state_q == REQ);
  assign totalValue = total_q;
  assign finish     = finish_q;
  assign bust       = bust_q;
  assign card_count = count_q;
  assign card_err   = err_q;

endmodule

// File: tb/tb_player_hand.sv
// Randomised bench for player_hand: a hand-level model (list of accepted ranks) predicts every output each cycle.
module tb_player_hand;

  logic       clock = 1'b0;
  logic       new_Game = 1'b1;
  logic       cardReady = 1'b0;
  logic       card_ack = 1'b0;
  logic [3:0] card_rank = 4'd0;
  logic       card_req;
  logic [4:0] totalValue;
  logic       finish;
  logic       bust;
  logic [2:0] card_count;
  logic       card_err;

  player_hand dut (
    .clock      (clock),
    .new_Game   (new_Game),
    .cardReady  (cardReady),
    .card_ack   (card_ack),
    .card_rank  (card_rank),
    .card_req   (card_req),
    .totalValue (totalValue),
    .finish     (finish),
    .bust       (bust),
    .card_count (card_count),
    .card_err   (card_err)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;
  bit armed   = 1'b0;
  bit resp_en = 1'b0;
  int rank_queue[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: the hand as a list of ranks ----------------
  int hand[$];
  int exp_total = 0, exp_count = 0;
  bit exp_fin = 0, exp_bust = 0, exp_err = 0;
  int nxt_total = 0, nxt_count = 0;
  bit nxt_fin = 0, nxt_bust = 0;
  bit d1 = 0, d2 = 0;

  function automatic int model_total();
    int hard = 0;
`ifdef PLAYER_SOFT_ACE_EN
    bit ace = 0;
`endif
    foreach (hand[i]) begin
      hard += (hand[i] == 1) ? 1 : ((hand[i] >= 10) ? 10 : hand[i]);
`ifdef PLAYER_SOFT_ACE_EN
      if (hand[i] == 1) ace = 1;
`endif
    end
`ifdef PLAYER_SOFT_ACE_EN
    if (ace && hard + 10 <= 21) hard += 10;
`endif
    return (hard > 31) ? 31 : hard;
  endfunction

  // Accepted card at edge E: total/count visible after E+1, finish/bust after E+2.
  initial forever begin
    @(posedge clock);
    if (new_Game) begin
      hand.delete();
      exp_total = 0; exp_count = 0; exp_fin = 0; exp_bust = 0; exp_err = 0;
      d1 = 0; d2 = 0;
    end else begin
      exp_err = 0;
      if (d2) begin
        exp_fin  = nxt_fin;
        exp_bust = nxt_bust;
        d2 = 0;
      end
      if (d1) begin
        exp_total = nxt_total;
        exp_count = nxt_count;
        d1 = 0;
        d2 = 1;
      end
      if (card_ack && card_req) begin
        if (card_rank >= 4'd1 && card_rank <= 4'd13) begin
          hand.push_back(int'(card_rank));
          nxt_total = model_total();
          nxt_count = hand.size();
          nxt_bust  = nxt_total > 21;
          nxt_fin   = nxt_bust || nxt_total >= 17 || nxt_count == 5;
          d1 = 1;
        end else begin
          exp_err = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (armed) begin
      check("totalValue", int'(totalValue), exp_total);
      check("card_count", int'(card_count), exp_count);
      check("finish", int'(finish), int'(exp_fin));
      check("bust", int'(bust), int'(exp_bust));
      check("card_err", int'(card_err), int'(exp_err));
      if (exp_fin) check("req_in_done", int'(card_req), 0);
    end
  end

  // ---------------- deck responder ----------------
  initial forever begin
    @(negedge clock);
    if (resp_en && card_req) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      if (resp_en && card_req) begin
        if (rank_queue.size() > 0) card_rank = 4'(rank_queue.pop_front());
        else if ($urandom_range(0, 99) < 6) card_rank = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'(14 + $urandom_range(0, 1));
        else card_rank = 4'($urandom_range(1, 13));
        card_ack = 1'b1;
        @(negedge clock);
        card_ack  = 1'b0;
        card_rank = 4'($urandom_range(0, 15));
        check("req_drop_after_ack", int'(card_req), 0);
      end
    end
  end

  task automatic do_reset();
    new_Game  = 1'b1;
    cardReady = 1'b0;
    @(negedge clock);
    new_Game  = 1'b0;
    rank_queue.delete();
    @(negedge clock);
  endtask

  task automatic strobe(input int cycles);
    cardReady = 1'b1;
    repeat (cycles) @(negedge clock);
    cardReady = 1'b0;
  endtask

  task automatic wait_finish(input int budget);
    for (int i = 0; i < budget && !finish; i++) @(negedge clock);
    check("finish_within_budget", int'(finish), 1);
  endtask

  task automatic random_game(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      new_Game  = ($urandom_range(0, 199) == 0);
      cardReady = ($urandom_range(0, 2) == 0);
      @(negedge clock);
    end
    new_Game  = 1'b0;
    cardReady = 1'b0;
  endtask

  int seen[$];
  int last_cnt;
  int exp_seq[4];

  initial begin
    @(negedge clock);
    @(negedge clock);
    new_Game = 1'b0;
    @(negedge clock);
    armed   = 1'b1;
    resp_en = 1'b1;

    // Reset after random activity.
    random_game(25);
    new_Game = 1'b1;
    @(negedge clock);
    new_Game = 1'b0;
    check("rst_total", int'(totalValue), 0);
    check("rst_count", int'(card_count), 0);
    check("rst_finish", int'(finish), 0);
    check("rst_bust", int'(bust), 0);
    check("rst_err", int'(card_err), 0);
    check("rst_req", int'(card_req), 0);
    @(negedge clock);

    // Initial deal 10 + 7.
    do_reset();
    rank_queue = '{10, 7};
    strobe(2);
    wait_finish(40);
    @(negedge clock);
    check("deal_total", int'(totalValue), 17);
    check("deal_count", int'(card_count), 2);
    check("deal_finish", int'(finish), 1);
    check("deal_bust", int'(bust), 0);
    strobe(1);
    repeat (6) begin
      check("deal_no_third_req", int'(card_req), 0);
      @(negedge clock);
    end

    // Soft ace: A + 6.
    do_reset();
    rank_queue = '{1, 6};
    strobe(2);
    for (int i = 0; i < 40 && card_count != 3'd2; i++) @(negedge clock);
    repeat (3) @(negedge clock);
`ifdef PLAYER_SOFT_ACE_EN
    check("soft_total", int'(totalValue), 17);
    check("soft_finish", int'(finish), 1);
`else
    check("soft_total", int'(totalValue), 7);
    check("soft_finish", int'(finish), 0);
`endif
    check("soft_req_idle", int'(card_req), 0);

    // Demotion then bust: A, 5, 9, 10 with cardReady held.
    do_reset();
    rank_queue = '{1, 5, 9, 10};
`ifdef PLAYER_SOFT_ACE_EN
    exp_seq = '{11, 16, 15, 25};
`else
    exp_seq = '{1, 6, 15, 25};
`endif
    seen.delete();
    last_cnt = 0;
    cardReady = 1'b1;
    for (int i = 0; i < 80 && !finish; i++) begin
      @(negedge clock);
      if (int'(card_count) != last_cnt) begin
        last_cnt = int'(card_count);
        seen.push_back(int'(totalValue));
      end
    end
    check("bust_cards", seen.size(), 4);
    for (int i = 0; i < 4; i++) check("bust_running_total", (i < seen.size()) ? seen[i] : -1, exp_seq[i]);
    check("bust_flag", int'(bust), 1);
    check("bust_finish", int'(finish), 1);
    repeat (8) begin
      @(negedge clock);
      check("bust_req_stays_low", int'(card_req), 0);
    end
    cardReady = 1'b0;

    // Five-card limit.
    do_reset();
    rank_queue = '{2, 2, 2, 2, 2};
    cardReady = 1'b1;
    wait_finish(120);
    cardReady = 1'b0;
    @(negedge clock);
    check("five_total", int'(totalValue), 10);
    check("five_count", int'(card_count), 5);
    check("five_finish", int'(finish), 1);
    check("five_bust", int'(bust), 0);

    // Invalid rank, then new_Game while requesting (manual deck).
    resp_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    do_reset();
    cardReady = 1'b1;
    @(negedge clock);
    cardReady = 1'b0;
    check("req_latency", int'(card_req), 1);
    card_ack  = 1'b1;
    card_rank = 4'd0;
    @(negedge clock);
    card_ack = 1'b0;
    check("err_pulse", int'(card_err), 1);
    check("err_count", int'(card_count), 0);
    check("err_req_low", int'(card_req), 0);
    @(negedge clock);
    check("err_pulse_ends", int'(card_err), 0);
    cardReady = 1'b1;
    @(negedge clock);
    cardReady = 1'b0;
    check("req_again", int'(card_req), 1);
    new_Game = 1'b1;
    @(negedge clock);
    new_Game = 1'b0;
    check("reset_drops_req", int'(card_req), 0);
    card_ack  = 1'b1;
    card_rank = 4'd5;
    @(negedge clock);
    card_ack = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("late_ack_total", int'(totalValue), 0);
      check("late_ack_count", int'(card_count), 0);
    end

    // Randomised games against the model.
    resp_en = 1'b1;
    for (int g = 0; g < 40; g++) begin
      do_reset();
      random_game(60);
    end
    resp_en = 1'b0;
    repeat (4) @(negedge clock);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/player_hand.md
# player_hand

Per-player responder to the game controller's dealing strobes. Each card-ready cycle from the controller is turned into a card fetch from the deck via a req/ack handshake. The block converts the rank to a blackjack value, keeps the running total with ace handling, and raises `finish` when the player stands, busts or fills the hand. One instance serves the Master seat and one serves the Slave seat; their `totalValue`/`finish` outputs feed the controller.

## Interface
- `STAND_THRESHOLD`, default 17: stand when total ≥ this value.
- `MAX_CARDS`, default 5: hand-size limit (range 2–7).

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `new_Game` in 1: reset, synchronous, active-high; clears the hand.
- `cardReady` in 1: deal request level from the controller, sampled every cycle.
- `card_ack` in 1: deck strobe, one cycle; `card_rank` is valid in the same cycle.
- `card_rank` in 4: 1 = ace, 2–10 = pip, 11–13 = J/Q/K; 0 and 14–15 are invalid.
- `card_req` out 1: card request to the deck; held high until `card_ack`.
- `totalValue` out 5: current hand total (0–30).
- `finish` out 1: hand closed (stand, bust or full); sticky until `new_Game`.
- `bust` out 1: total > 21; sticky.
- `card_count` out 3: number of accepted cards.
- `card_err` out 1: one-cycle pulse when an invalid rank is acked.

## Operation
- States: IDLE, REQ, ADD, CHECK, DONE.
- IDLE:
  - `cardReady` = 1 → REQ.
  - `cardReady` = 0 → stay in IDLE.
  - `pending` = 1 → REQ and clear `pending`.
- Pending flag:
  - Set by `cardReady` = 1 in any cycle spent in REQ, ADD or CHECK.
  - Holds one owed deal, so a 2-cycle strobe yields 2 cards.
  - A held-high `cardReady` yields continuous hits.
- REQ:
  - `card_req` = 1.
  - On `card_ack`, latch the rank and go to ADD.
  - An invalid rank pulses `card_err`, latches nothing and returns to IDLE; `card_count` is unchanged.
- ADD: value rules.
  - Rank 1 → 11 (soft) or 1 (see Configuration).
  - Ranks 2–10 → face value.
  - Ranks 11–13 → 10.
- ADD: arithmetic.
  - 6-bit internal sum = total + value.
  - If sum > 21 and `soft_aces` > 0 (new ace included): subtract 10 and decrement `soft_aces`.
  - Register `totalValue` and increment `card_count`.
  - Then go to CHECK.
- CHECK:
  - Total > 21 → `bust` = 1 and `finish` = 1, go to DONE.
  - Total ≥ `STAND_THRESHOLD` (soft totals included) → `finish` = 1, go to DONE.
  - `card_count` = `MAX_CARDS` → `finish` = 1, go to DONE.
  - Otherwise → IDLE.
- DONE: ignores `cardReady` and `card_ack`; clears `pending`; `card_req` = 0.
- Maximum reachable hard total is 30, so the 5-bit output never overflows. It saturates at 31 defensively.

## Timing
- Reset values: `card_req` 0, `totalValue` 0, `finish` 0, `bust` 0, `card_count` 0, `card_err` 0, state IDLE, `pending` 0, `soft_aces` 0.
- `new_Game` wins over every simultaneous event; a `card_ack` in the same cycle is discarded.
- `new_Game` during REQ drops `card_req` at the next edge. A late `card_ack` then arriving in IDLE is ignored.
- Per-card latency:
  - `cardReady` sampled high at edge t.
  - `card_req` high from t+1.
  - Ack at the earliest in cycle t+1 → ADD at t+2.
  - `totalValue`/`card_count` visible from t+3; CHECK at t+3.
  - `finish`/`bust` visible from t+4.
  - Next REQ at t+4 when `pending`.
- `card_req` deasserts the cycle after `card_ack`. `card_ack` while `card_req` = 0 is ignored.
- `finish` and `bust` are registered, glitch-free and sticky.

## Configuration
- `PLAYER_SOFT_ACE_EN`:
  - Defined: an ace enters as 11 and increments `soft_aces`; it is demoted to 1 on bust as described under Operation.
  - Undefined: an ace is always 1, the `soft_aces` logic is removed, and the sum is never adjusted.

## Test plan
- Reset: assert `new_Game` 1 cycle after random activity → all outputs 0 on the next edge; `card_req` 0.
- Initial deal: `cardReady` high 2 cycles, acks rank 10 then 7 → `totalValue` 17, `card_count` 2, `finish` 1, `bust` 0. A third `cardReady` makes no `card_req`.
- Soft ace: ranks 1, 6.
  - With `PLAYER_SOFT_ACE_EN` → total 17, `finish` 1.
  - Without it → total 7, `finish` 0, and the block returns to IDLE.
- Demotion then bust (macro on): `cardReady` held, ranks 1, 5, 9, 10 → totals 11, 16, 15, 25; `bust` 1 and `finish` 1 after the 4th card; `card_req` stays 0 afterwards.
- Five-card limit: `cardReady` held, ranks 2, 2, 2, 2, 2 → total 10, `card_count` 5, `finish` 1, `bust` 0.
- Error and reset mid-request:
  - Ack rank 0 → `card_err` pulse, count unchanged.
  - `new_Game` while `card_req` = 1 → `card_req` 0 next cycle; a following ack with rank 5 leaves the total at 0.
